cm0ik_input_delay_sched: RTL and testbench

- Cycle-accurate scheduler for delayed input changes on the integration-kit testbench. It is the clocked counterpart of the fixed time-delay input buffer.
- Accepts a queue of (value, delay-in-cycles) events and applies each value to a core-facing input bus (IRQ, NMI, RXEV, etc.) after its programmed delay.
- Events are applied strictly in acceptance order.
- Sits between the testbench stimulus driver and the time-delay buffers in front of the netlist inputs.

---
 rtl/cm0ik_sched_pkg.sv | 28 ++
 rtl/cm0ik_sched_fifo.sv | 79 +++++++
 rtl/cm0ik_input_delay_sched.sv | 150 +++++++++++++++
 tb/tb_cm0ik_input_delay_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cm0ik_sched_pkg.sv
// cm0ik_sched_pkg
// Shared types for the clocked input-delay scheduler.
//   - sched_state_t : countdown FSM states (IDLE, WAIT)
//   - sched_evt_t   : event record {data, delay} at the default bus/counter widths.
//     The top module declares the same layout locally so it follows its own
//     BUSWIDTH/CNTW parameters.
//   - sched_ptr_w() : pointer width for a given queue depth
package cm0ik_sched_pkg;

    localparam int unsigned DEF_BUSWIDTH = 1;
    localparam int unsigned DEF_CNTW     = 8;
    localparam int unsigned DEF_DEPTH    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } sched_state_t;

    typedef struct packed {
        logic [DEF_BUSWIDTH-1:0] data;
        logic [DEF_CNTW-1:0]     delay;
    } sched_evt_t;

    function automatic int unsigned sched_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/cm0ik_sched_fifo.sv
// cm0ik_sched_fifo
// Circular event buffer of DEPTH entries, WIDTH bits each.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, wdata     write request and entry (ignored while full)
//   pop             discard head entry (ignored while empty)
//   flush           synchronous discard of every entry; dominates push/pop
//   rdata           head entry, valid whenever empty is low
//   level           number of stored entries
//   full, empty     derived from the registered level
// The head is read combinationally: the scheduler must act on a new head in
// the very cycle it appears, so the store stays a small register array.
module cm0ik_sched_fifo
    import cm0ik_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = sched_ptr_w(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [LW-1:0]    level_reg;
    logic             push_en;
    logic             pop_en;

    assign full    = (level_reg == LW'(DEPTH));
    assign empty   = (level_reg == '0);
    assign push_en = push && !full && !flush;
    assign pop_en  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr_reg];
    assign level   = level_reg;

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push_en && !pop_en) begin
                level_reg <= level_reg + 1'b1;
            end else if (pop_en && !push_en) begin
                level_reg <= level_reg - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cm0ik_input_delay_sched.sv
// cm0ik_input_delay_sched
// Cycle-accurate scheduler that applies queued (value, delay) events to a
// core-facing input bus, strictly in acceptance order.
// Ports:
//   HCLK, HRESETn   clock, asynchronous active-low reset
//   evt_valid/ready push handshake; evt_ready is low only when the queue is full
//   evt_data        value to apply
//   evt_delay       cycles to wait once the event is at the queue head
//   flush           drop all pending events and any running countdown
//   dataout         scheduled bus (registered)
//   applied         one-cycle pulse after each dataout update
//   busy            queue non-empty or countdown running
//   level           queued events, head included
module cm0ik_input_delay_sched
    import cm0ik_sched_pkg::*;
#(
    parameter int unsigned          BUSWIDTH  = 1,
    parameter int unsigned          DEPTH     = 4,
    parameter int unsigned          CNTW      = 8,
    parameter logic [BUSWIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic                   evt_valid,
    output logic                   evt_ready,
    input  logic [BUSWIDTH-1:0]    evt_data,
    input  logic [CNTW-1:0]        evt_delay,
    input  logic                   flush,
    output logic [BUSWIDTH-1:0]    dataout,
    output logic                   applied,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("cm0ik_input_delay_sched: DEPTH must be a power of two, at least 2");
    end

    typedef struct packed {
        logic [BUSWIDTH-1:0] data;
        logic [CNTW-1:0]     delay;
    } evt_t;

    evt_t          wr_evt;
    evt_t          head_evt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          apply;

    sched_state_t        state_reg, state_next;
    logic [CNTW-1:0]     cnt_reg, cnt_next;
    logic [BUSWIDTH-1:0] dataout_reg, dataout_next;
    logic                applied_reg;

    assign wr_evt    = '{data: evt_data, delay: evt_delay};
    // No push while full, even if the head pops this cycle; flush drops the push.
    assign evt_ready = !fifo_full;
    assign push      = evt_valid && !fifo_full && !flush;

    cm0ik_sched_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(evt_t))
    ) u_fifo (
        .clk   (HCLK),
        .rst_n (HRESETn),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wr_evt),
        .rdata (head_evt),
        .level (level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A head with delay D seen in IDLE loads D-1, so the WAIT state expires on
    // the D-th edge; delay 0 is applied straight from IDLE.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        pop        = 1'b0;
        apply      = 1'b0;
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_evt.delay == '0) begin
                            apply = 1'b1;
                            pop   = 1'b1;
                        end else begin
                            cnt_next   = head_evt.delay - 1'b1;
                            state_next = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_reg != '0) begin
                        cnt_next = cnt_reg - 1'b1;
                    end else begin
                        apply      = 1'b1;
                        pop        = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

    assign dataout_next = apply ? head_evt.data : dataout_reg;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            dataout_reg <= RESET_VAL;
            applied_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            dataout_reg <= dataout_next;
            applied_reg <= apply;
        end
    end

    assign dataout = dataout_reg;
    assign applied = applied_reg;
    assign busy    = (level != '0) || (state_reg == WAIT);

`ifndef SYNTHESIS
    always @(posedge HCLK) begin
        if (HRESETn) begin
            if ($isunknown(evt_valid)) begin
                $error("cm0ik_input_delay_sched: evt_valid is X");
            end else if (evt_valid && ($isunknown(evt_data) || $isunknown(evt_delay))) begin
                $error("cm0ik_input_delay_sched: evt_data/evt_delay X while evt_valid high");
            end
        end
    end
`endif

endmodule

// File: tb/tb_cm0ik_input_delay_sched.sv
module tb_cm0ik_input_delay_sched;

    localparam int BW    = 1;
    localparam int DEPTH = 4;
    localparam int CNTW  = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          HCLK      = 1'b0;
    logic          HRESETn   = 1'b0;
    logic          evt_valid = 1'b0;
    logic [BW-1:0] evt_data  = '0;
    logic [CNTW-1:0] evt_delay = '0;
    logic          flush     = 1'b0;
    logic          evt_ready;
    logic [BW-1:0] dataout;
    logic          applied;
    logic          busy;
    logic [LW-1:0] level;

    cm0ik_input_delay_sched #(
        .BUSWIDTH  (BW),
        .DEPTH     (DEPTH),
        .CNTW      (CNTW),
        .RESET_VAL (1'b0)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_delay (evt_delay),
        .flush     (flush),
        .dataout   (dataout),
        .applied   (applied),
        .busy      (busy),
        .level     (level)
    );

    always #5 HCLK = ~HCLK;

    // Scoreboard entry: value, delay and the edge index at which it was accepted.
    typedef struct {
        logic [BW-1:0] data;
        int            delay;
        int            push_edge;
    } sb_t;

    sb_t sbq[$];
    int  cyc        = 0;
    int  last_apply = -100;
    int  n_cmp      = 0;
    int  n_err      = 0;

    always @(posedge HCLK) cyc <= cyc + 1;

    // Head is evaluated one cycle after acceptance or after the previous apply,
    // whichever is later; the update lands delay edges after that.
    function automatic int exp_edge(input sb_t e);
        int h;
        h = e.push_edge + 1;
        if (last_apply + 1 > h) h = last_apply + 1;
        return h + e.delay;
    endfunction

    // Scoreboard monitor: outputs sampled on the falling edge after edge cyc.
    always @(negedge HCLK) begin
        int            sz0;
        int            ee;
        sb_t           f;
        logic [LW-1:0] exp_lvl;
        if (!HRESETn) begin
            sbq.delete();
            last_apply = -100;
        end else begin
            sz0 = sbq.size();
            if (flush === 1'b1) begin
                n_cmp++;
                if (applied !== 1'b0) begin
                    n_err++;
                    $display("FAIL flush_applied edge=%0d applied=%b required=0", cyc, applied);
                end
                sbq.delete();
            end else begin
                if (applied === 1'b1) begin
                    n_cmp++;
                    if (sbq.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_apply edge=%0d dataout=%h", cyc, dataout);
                    end else begin
                        f  = sbq.pop_front();
                        ee = exp_edge(f);
                        if (cyc != ee || dataout !== f.data) begin
                            n_err++;
                            $display("FAIL apply edge=%0d data=%h required edge=%0d data=%h",
                                     cyc, dataout, ee, f.data);
                        end
                        last_apply = cyc;
                    end
                end else if (sbq.size() != 0) begin
                    ee = exp_edge(sbq[0]);
                    n_cmp++;
                    if (ee <= cyc) begin
                        n_err++;
                        $display("FAIL missing_apply edge=%0d required edge=%0d data=%h",
                                 cyc, ee, sbq[0].data);
                        void'(sbq.pop_front());
                        last_apply = cyc;
                    end
                end
                if (evt_valid === 1'b1 && sz0 < DEPTH) begin
                    sbq.push_back('{data: evt_data, delay: int'(evt_delay), push_edge: cyc});
                end
            end
            exp_lvl = LW'(sbq.size());
            n_cmp++;
            if (level !== exp_lvl || evt_ready !== (sbq.size() != DEPTH) ||
                busy !== (sbq.size() != 0)) begin
                n_err++;
                $display("FAIL status edge=%0d level=%0d ready=%b busy=%b required level=%0d ready=%b busy=%b",
                         cyc, level, evt_ready, busy, exp_lvl, sbq.size() != DEPTH, sbq.size() != 0);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge HCLK);
        #1;
    endtask

    task automatic push_evt(input logic [BW-1:0] d, input int dly, input int budget,
                            output int acc_edge);
        bit done;
        done      = 1'b0;
        evt_valid = 1'b1;
        evt_data  = d;
        evt_delay = CNTW'(dly);
        for (int k = 0; k < budget && !done; k++) begin
            done = (evt_ready === 1'b1);
            tick(1);
        end
        acc_edge  = cyc;
        evt_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_err++;
            $display("FAIL push_timeout data=%h delay=%0d ready=%b required=1", d, dly, evt_ready);
        end
        $display("push data=%h delay=%0d edge=%0d", d, dly, acc_edge);
    endtask

    task automatic wait_until(input int target);
        for (int k = 0; k < 400 && cyc < target; k++) tick(1);
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget && !(busy === 1'b0 && sbq.size() == 0); k++) tick(1);
        n_cmp++;
        if (busy !== 1'b0 || sbq.size() != 0) begin
            n_err++;
            $display("FAIL idle_timeout busy=%b pending=%0d required busy=0 pending=0", busy, sbq.size());
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (dataout !== 1'b0 || applied !== 1'b0 || busy !== 1'b0 || level !== '0 || evt_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset dataout=%h applied=%b busy=%b level=%0d ready=%b required 0 0 0 0 1",
                     dataout, applied, busy, level, evt_ready);
        end
        tick(2);
        HRESETn = 1'b1;
        tick(1);
        $display("reset released at edge %0d", cyc);
    endtask

    task automatic test_delay0();
        int p;
        push_evt(1'b1, 0, 4, p);
        n_cmp++;
        if (applied !== 1'b0 || dataout !== 1'b0) begin
            n_err++;
            $display("FAIL d0_push_edge applied=%b dataout=%h required 0 0", applied, dataout);
        end
        tick(1);
        n_cmp++;
        if (applied !== 1'b1 || dataout !== 1'b1) begin
            n_err++;
            $display("FAIL d0_apply applied=%b dataout=%h required 1 1", applied, dataout);
        end
        tick(1);
        n_cmp++;
        if (applied !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL d0_after applied=%b busy=%b required 0 0", applied, busy);
        end
    endtask

    task automatic test_back_to_back();
        int p1, p2;
        push_evt(1'b1, 3, 4, p1);
        push_evt(1'b0, 0, 4, p2);
        wait_until(p1 + 4);
        n_cmp++;
        if (applied !== 1'b1 || dataout !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_first applied=%b dataout=%h required 1 1", applied, dataout);
        end
        tick(1);
        n_cmp++;
        if (applied !== 1'b1 || dataout !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second applied=%b dataout=%h required 1 0", applied, dataout);
        end
        wait_idle(20);
    endtask

    task automatic test_full_wrap();
        int p;
        for (int i = 0; i < 4; i++) push_evt(BW'(i % 2 == 0), 10, 4, p);
        n_cmp++;
        if (evt_ready !== 1'b0 || level !== LW'(4)) begin
            n_err++;
            $display("FAIL full ready=%b level=%0d required 0 4", evt_ready, level);
        end
        push_evt(1'b1, 10, 40, p);
        wait_idle(120);
        n_cmp++;
        if (dataout !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_last dataout=%h required 1", dataout);
        end
    endtask

    task automatic test_flush();
        int p;
        push_evt(1'b0, 0, 4, p);
        wait_idle(10);
        push_evt(1'b1, 20, 4, p);
        tick(5);
        flush     = 1'b1;
        evt_valid = 1'b1;
        evt_data  = 1'b1;
        evt_delay = '0;
        tick(1);
        flush     = 1'b0;
        evt_valid = 1'b0;
        n_cmp++;
        if (dataout !== 1'b0 || level !== '0 || busy !== 1'b0 || applied !== 1'b0) begin
            n_err++;
            $display("FAIL flush dataout=%h level=%0d busy=%b applied=%b required 0 0 0 0",
                     dataout, level, busy, applied);
        end
        tick(30);
        n_cmp++;
        if (dataout !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_after dataout=%h busy=%b required 0 0", dataout, busy);
        end
    endtask

    task automatic test_max_delay();
        int p;
        push_evt(1'b1, 255, 4, p);
        wait_until(p + 255);
        n_cmp++;
        if (applied !== 1'b0 || dataout !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL max_early applied=%b dataout=%h busy=%b required 0 0 1", applied, dataout, busy);
        end
        tick(1);
        n_cmp++;
        if (applied !== 1'b1 || dataout !== 1'b1) begin
            n_err++;
            $display("FAIL max_apply applied=%b dataout=%h required 1 1", applied, dataout);
        end
        wait_idle(5);
    endtask

    task automatic test_async_reset();
        int p;
        push_evt(1'b1, 50, 4, p);
        tick(10);
        #2;
        HRESETn = 1'b0;
        #1;
        n_cmp++;
        if (dataout !== 1'b0 || applied !== 1'b0 || busy !== 1'b0 || level !== '0 || evt_ready !== 1'b1) begin
            n_err++;
            $display("FAIL async_reset dataout=%h applied=%b busy=%b level=%0d ready=%b required 0 0 0 0 1",
                     dataout, applied, busy, level, evt_ready);
        end
        tick(2);
        HRESETn = 1'b1;
        tick(60);
        n_cmp++;
        if (dataout !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL async_after dataout=%h busy=%b required 0 0", dataout, busy);
        end
    endtask

    initial begin
        test_reset();
        test_delay0();
        test_back_to_back();
        test_full_wrap();
        test_flush();
        test_max_delay();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog edge=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
